// File: rtl/scan_ctrl.sv
// scan_ctrl: two-requester table search engine.
// Accepts one search at a time (round-robin between req0/req1), streams
// table reads from entry 0 upward, and reports the first entry whose value
// field equals the latched key, or a miss after the last entry.
module scan_ctrl #(
  parameter int unsigned DEPTH = 9,
  parameter int unsigned W     = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic [W-1:0]   key0,
  input  logic           req1,
  input  logic [W-1:0]   key1,
  output logic           rd_en,
  output logic [3:0]     rd_addr,
  input  logic [3*W-1:0] rd_data,
  output logic           busy,
  output logic           done,
  output logic           owner,
  output logic           found,
  output logic [W-1:0]   i1,
  output logic [W-1:0]   i2,
  output logic [W-1:0]   value
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [3:0] LAST = 4'(DEPTH - 1);

  state_t       state_q,   state_d;
  logic [W-1:0] key_q,     key_d;
  logic         cur_q,     cur_d;      // requester being served
  logic         prio1_q,   prio1_d;    // 1: req1 wins a tie
  logic         rd_en_q,   rd_en_d;
  logic [3:0]   rd_addr_q, rd_addr_d;
  logic         vld_q,     vld_d;      // rd_data carries entry cmp_idx_q this cycle
  logic [3:0]   cmp_idx_q, cmp_idx_d;
  logic         busy_q,    busy_d;
  logic         done_q,    done_d;
  logic         owner_q,   owner_d;
  logic         found_q,   found_d;
  logic [W-1:0] i1_q,      i1_d;
  logic [W-1:0] i2_q,      i2_d;
  logic [W-1:0] value_q,   value_d;

  logic         arb_prio;
  logic         pick;
  logic         match;

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign owner   = owner_q;
  assign found   = found_q;
  assign i1      = i1_q;
  assign i2      = i2_q;
  assign value   = value_q;

  // Arbitration and comparison. In DONE the pointer update is applied to the
  // tie-break immediately so a back-to-back acceptance already sees it.
  always_comb begin
    arb_prio = (state_q == DONE) ? ~owner_q : prio1_q;
    pick     = (req0 && req1) ? arb_prio : req1;
    match    = vld_q && (rd_data[3*W-1:2*W] == key_q);
  end

  // Next-state and next-output computation for the search FSM.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    cur_d     = cur_q;
    prio1_d   = prio1_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    vld_d     = vld_q;
    cmp_idx_d = cmp_idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    owner_d   = owner_q;
    found_d   = found_q;
    i1_d      = i1_q;
    i2_d      = i2_q;
    value_d   = value_q;

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) prio1_d = ~owner_q;
        state_d   = IDLE;
        busy_d    = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
        vld_d     = 1'b0;
        if (req0 || req1) begin
          state_d   = SCAN;
          busy_d    = 1'b1;
          cur_d     = pick;
          key_d     = pick ? key1 : key0;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end
      end

      SCAN: begin
        vld_d     = rd_en_q;
        cmp_idx_d = rd_addr_q;
        if (rd_en_q) begin
          if (rd_addr_q == LAST) begin
            rd_en_d   = 1'b0;
            rd_addr_d = '0;
          end else begin
            rd_addr_d = rd_addr_q + 4'd1;
          end
        end
        if (match || (vld_q && cmp_idx_q == LAST)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          owner_d   = cur_q;
          found_d   = match;
          i1_d      = match ? rd_data[W-1:0]     : '0;
          i2_d      = match ? rd_data[2*W-1:W]   : '0;
          value_d   = match ? rd_data[3*W-1:2*W] : '0;
          rd_en_d   = 1'b0;
          rd_addr_d = '0;
          vld_d     = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      key_q     <= '0;
      cur_q     <= 1'b0;
      prio1_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      vld_q     <= 1'b0;
      cmp_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      owner_q   <= 1'b0;
      found_q   <= 1'b0;
      i1_q      <= '0;
      i2_q      <= '0;
      value_q   <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      cur_q     <= cur_d;
      prio1_q   <= prio1_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      vld_q     <= vld_d;
      cmp_idx_q <= cmp_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      owner_q   <= owner_d;
      found_q   <= found_d;
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      value_q   <= value_d;
    end
  end

endmodule

// File: doc/scan_ctrl.md
SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 Parameter DEPTH, default 9: number of table entries searched.
REQ-002 Parameter W, default 8: width of each entry field and of the key.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0  input  1  requester 0 search request; level, held until its done.
REQ-006 key0  input  W  requester 0 search key.
REQ-007 req1  input  1  requester 1 search request; level, held until its done.
REQ-008 key1  input  W  requester 1 search key.
REQ-009 rd_en  output  1  table read strobe.
REQ-010 rd_addr  output  4  table entry index, 0..DEPTH-1.
REQ-011 rd_data  input  3*W  entry returned one cycle after rd_en: [W-1:0]=i1, [2W-1:W]=i2, [3W-1:2W]=value.
REQ-012 busy  output  1  high from acceptance through the done cycle.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 owner  output  1  requester served; valid while done is high.
REQ-015 found  output  1  1 = match; 0 = miss.
REQ-016 i1, i2, value  output  W each  fields of the matching entry.

Function
REQ-017 FSM states: IDLE, SCAN, DONE.
REQ-018 IDLE: if req0 or req1 is high at an edge, SHALL accept exactly one request, latch its key and owner, and go to SCAN.
REQ-019 Arbitration: round-robin; single request wins; if both are high, the requester not served last wins; after reset req0 has priority.
REQ-020 Requests arriving while busy is high SHALL be ignored until the block returns to IDLE.
REQ-021 SCAN: rd_en=1 with rd_addr=0,1,2,... in consecutive cycles starting one cycle after acceptance; rd_en=0 otherwise.
REQ-022 rd_data for entry k SHALL be compared with the latched key in the following cycle; match = full W-bit equality of the value field.
REQ-023 The first (lowest-index) match ends the scan; reads already issued are discarded and no further reads are issued.
REQ-024 Match at entry k: done high k+3 cycles after the accepting edge, found=1, i1/i2/value = entry k fields.
REQ-025 No match: done high DEPTH+2 cycles after acceptance (11 for DEPTH=9), found=0, i1=i2=value=0.
REQ-026 rd_addr SHALL never exceed DEPTH-1 and SHALL NOT wrap.
REQ-027 DONE lasts exactly one cycle: done=1, busy=1; next state IDLE, with new acceptance possible on that following edge.
REQ-028 found, i1, i2, value, owner SHALL hold their values until the next done.
REQ-029 The round-robin pointer SHALL update only in the done cycle.

Reset
REQ-030 rst at any edge, including mid-SCAN: state=IDLE; rd_en, rd_addr, busy, done, owner, found, i1, i2, value all 0; RR pointer favours req0.
REQ-031 A scan interrupted by reset SHALL produce no done pulse, and the interrupted request SHALL be re-arbitrated if still held.

Verification
Table preload: entry k = {value=0x10+k, i2=0x80+k, i1=k}, k=0..8.
REQ-032 req0, key0=0x13 -> done 6 cycles after acceptance, owner=0, found=1, i1=0x03, i2=0x83, value=0x13; rd_addr 0..4 issued, never 5.
REQ-033 req1, key1=0xFF -> done 11 cycles after acceptance, owner=1, found=0, i1=i2=value=0; rd_addr 0..8 each exactly once.
REQ-034 Entries 2 and 5 set to value 0x55; key0=0x55 -> found=1, i1=0x02, done 5 cycles after acceptance.
REQ-035 req0 and req1 both high from reset, keys 0x10 and 0x18 -> req0 served first (done +3, i1=0), then req1 (done +11, i1=8); a further simultaneous request -> req0 wins.
REQ-036 rst asserted 4 cycles into a key=0x18 scan -> next cycle busy=0, rd_en=0, all outputs 0, no done pulse; with req0 still high, rescan completes with i1=8.
